cbus_arbiter: RTL and testbench
===============================

# cbus_arbiter

Arbitrates one shared cache-bus (CBus) master port among `NUM_INPUTS` requesters: instruction cache, data cache, and uncached paths. Each requester presents a `cbus_req_t` and receives a `cbus_resp_t`. The arbiter locks a grant for the whole transaction, single-beat or burst, until the final beat completes. It sits between the cache layer and the CBus-to-AXI bridge.

## Interface
Parameters:
- `NUM_INPUTS`, default 2: number of requesters, 2..8.
- `ROUND_ROBIN`, default 1:
  - 1: rotating priority.
  - 0: fixed priority, index 0 highest.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `ireqs`  in  `cbus_req_t [NUM_INPUTS]`  requests from the upstream caches.
- `oresps`  out  `cbus_resp_t [NUM_INPUTS]`  responses to the upstream caches.
- `oreq`  out  `cbus_req_t`  request to the shared bus.
- `iresp`  in  `cbus_resp_t`  response from the shared bus (`ready`, `last`, `data`).

## Operation
- Registers:
  - `state` ∈ {IDLE, BUSY}.
  - `index`: granted requester, `$clog2(NUM_INPUTS)` bits.
  - `prio`: round-robin start pointer, same width.
- IDLE, arbitration:
  - If any `ireqs[i].valid`, pick the first valid i scanning `prio, prio+1, …` modulo `NUM_INPUTS`. With `ROUND_ROBIN`=0 the scan starts at 0.
  - Register the pick into `index` and go to BUSY.
  - With no valid request, stay in IDLE.
- BUSY:
  - `oreq = ireqs[index]` (all fields passed through).
  - `oresps[index] = iresp`; every other `oresps[j] = '0`.
  - On `iresp.ready && iresp.last`: go to IDLE and set `prio <= index+1`, wrapping modulo `NUM_INPUTS`.
  - Requests arriving from other requesters are ignored until then.
- IDLE outputs: `oreq = '0` (valid=0); all `oresps = '0`.
- Modulo wrap: when `NUM_INPUTS` is not a power of 2, `index+1 == NUM_INPUTS` wraps to 0.
- Requester contract: it keeps `valid` and all request fields stable from assertion until it sees `ready&&last`. The arbiter does not re-check this.
- Granted `valid` drops mid-transaction (protocol violation):
  - The arbiter stays in BUSY and forwards `oreq.valid=0`.
  - It returns to IDLE only on `ready&&last`.
  - An assertion flags this in simulation.
- Reset (`reset==0` at a clock edge): `state<=IDLE`, `index<=0`, `prio<=0`. Reset mid-BUSY abandons the transaction; the bus side must also be reset.

## Timing
- Arbitration latency: valid seen in IDLE at cycle t → `oreq.valid=1` from cycle t+1.
- Completion: `ready&&last` in cycle t → `oresps[index].ready/last` are visible combinationally in cycle t; the arbiter is in IDLE at t+1.
- Next transaction: earliest `oreq.valid` at t+2, so there is one mandatory idle cycle between transactions.
- A single-beat transaction (`len`=MLEN1) with `ready`=`last`=1 on the first BUSY cycle occupies exactly 1 BUSY cycle.
- Throughput: no bubbles inside a burst; every `iresp.ready` beat is forwarded in the same cycle.
- Outputs out of reset, first cycle after reset deasserts: `oreq='0`, `oresps='0`.
- Simultaneous events: when completion and a new request coincide in cycle t, the new request is arbitrated in IDLE at t+1. The new `prio` is used.

## Test plan
- **Single requester read burst**: `ireqs[1]` valid, `len`=MLEN16, addr 0x8000_0080 at cycle 0 → `oreq` mirrors it from cycle 1. 16 beats of `iresp.data` reach `oresps[1]`; `oresps[0]` stays 0. IDLE after the `last` beat.
- **Contention, round-robin**: both requesters valid at cycle 0, `prio`=0 → grant 0 first, then 1. Repeat with both still valid → the order alternates 0,1,0,1 over 4 transactions.
- **Fixed priority** (`ROUND_ROBIN`=0): both requesters continuously valid → requester 0 granted every time; requester 1 is starved. This is expected behaviour.
- **Uncached single beat**: `ireqs[0]` valid, `is_write`=1, strobe 0x0F, `len`=MLEN1; `iresp` ready=last=1 in cycle 1 → `oresps[0].ready` in cycle 1, IDLE in cycle 2.
- **Lock during burst**: requester 0 in a 16-beat write; requester 1 asserts at beat 3 → `oreq` stays requester 0's fields until `last`. Requester 1 gets `oreq.valid` 2 cycles after `last`.
- **Reset mid-BUSY**: `reset=0` at beat 5 → next cycle IDLE, `oreq.valid=0`, all `oresps=0`, `prio=0`.

Source files
------------

// File: rtl/cbus_arbiter_if.sv
// CBus request/response types and the bundle connecting the arbiter to its
// requesters and to the shared bus.
package cbus_pkg;

  typedef enum logic [3:0] {
    MLEN1  = 4'b0000,
    MLEN2  = 4'b0001,
    MLEN4  = 4'b0011,
    MLEN8  = 4'b0111,
    MLEN16 = 4'b1111
  } cbus_len_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } cbus_size_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

interface cbus_arbiter_if #(
  parameter int NUM_INPUTS = 2
);
  import cbus_pkg::*;

  cbus_req_t  ireqs  [NUM_INPUTS];
  cbus_resp_t oresps [NUM_INPUTS];
  cbus_req_t  oreq;
  cbus_resp_t iresp;

  // master: requesters plus bus model; slave: the arbiter itself
  modport master (output ireqs, iresp, input oresps, oreq);
  modport slave  (input ireqs, iresp, output oresps, oreq);

endinterface

// File: rtl/cbus_arbiter.sv
// Shares one CBus master port among NUM_INPUTS requesters, holding the grant
// for a whole transaction until the bus reports ready && last.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic          clk,
  input  logic          reset,
  cbus_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_INPUTS);
  localparam int CW = IW + 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state, state_next;
  logic [IW-1:0] index, index_next;
  logic [IW-1:0] prio, prio_next;
  logic [IW-1:0] start;
  logic [IW-1:0] pick;
  logic [CW-1:0] cand;
  logic          found;
  logic          done;

  assign done  = bus.iresp.ready && bus.iresp.last;
  assign start = (ROUND_ROBIN != 0) ? prio : '0;

  // Scan start, start+1, ... with one extra bit so the wrap works for any N.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      cand = {1'b0, start} + CW'(k);
      if (cand >= CW'(NUM_INPUTS)) begin
        cand = cand - CW'(NUM_INPUTS);
      end
      if (!found && bus.ireqs[cand[IW-1:0]].valid) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      index <= '0;
      prio  <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
      prio  <= prio_next;
    end
  end

  always_comb begin
    state_next = state;
    index_next = index;
    prio_next  = prio;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = BUSY;
          index_next = pick;
        end
      end
      BUSY: begin
        if (done) begin
          state_next = IDLE;
          prio_next  = (index == IW'(NUM_INPUTS - 1)) ? '0 : index + IW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.oreq = '0;
    for (int unsigned j = 0; j < NUM_INPUTS; j++) begin
      bus.oresps[j] = '0;
    end
    if (state == BUSY) begin
      bus.oreq           = bus.ireqs[index];
      bus.oresps[index]  = bus.iresp;
    end
  end

  // The granted requester must hold valid until it has seen ready && last.
  a_grant_held: assert property (
    @(posedge clk) disable iff (!reset)
    (state == BUSY) |-> bus.ireqs[index].valid
  );

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: stimulus pushes per-cycle expected bus
// activity into a queue, a negedge monitor pops and compares.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int NI = 2;

  typedef struct {
    int unsigned cyc;
    cbus_req_t   req;
    int unsigned idx;
    cbus_resp_t  resp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  cbus_req_t   rq [NI];
  cbus_resp_t  bresp;
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  exp_t        q[$];

  cbus_arbiter_if #(.NUM_INPUTS(NI)) bus_rr ();
  cbus_arbiter_if #(.NUM_INPUTS(NI)) bus_fp ();

  cbus_arbiter #(.NUM_INPUTS(NI), .ROUND_ROBIN(1)) u_rr (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_rr)
  );

  cbus_arbiter #(.NUM_INPUTS(NI), .ROUND_ROBIN(0)) u_fp (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_fp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // sel routes the requesters and bus model to one arbiter; the other sits idle
  always_comb begin
    for (int i = 0; i < NI; i++) begin
      bus_rr.ireqs[i] = sel ? '0 : rq[i];
      bus_fp.ireqs[i] = sel ? rq[i] : '0;
    end
    bus_rr.iresp = sel ? '0 : bresp;
    bus_fp.iresp = sel ? bresp : '0;
  end

  always @(negedge clk) begin : monitor
    cbus_req_t  areq;
    cbus_resp_t ares [NI];
    cbus_resp_t want;
    logic       act;
    logic       other;
    exp_t       e;
    areq  = sel ? bus_fp.oreq : bus_rr.oreq;
    act   = (areq != '0);
    other = sel ? (bus_rr.oreq != '0) : (bus_fp.oreq != '0);
    for (int i = 0; i < NI; i++) begin
      ares[i] = sel ? bus_fp.oresps[i] : bus_rr.oresps[i];
      act     = act || (ares[i] != '0);
      other   = other || ((sel ? bus_rr.oresps[i] : bus_fp.oresps[i]) != '0);
    end
    vectors++;
    if (other) begin
      miscompares++;
      $display("FAIL idle_dut cyc=%0d: unselected arbiter drives outputs, required all zero", cyc);
    end
    if (act) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected cyc=%0d oreq=%h, required no bus activity", cyc, areq);
      end else begin
        e = q.pop_front();
        vectors++;
        if (e.cyc != cyc) begin
          miscompares++;
          $display("FAIL timing activity at cyc=%0d, required cyc=%0d", cyc, e.cyc);
        end
        vectors++;
        if (areq !== e.req) begin
          miscompares++;
          $display("FAIL oreq cyc=%0d got=%h required=%h", cyc, areq, e.req);
        end
        for (int i = 0; i < NI; i++) begin
          want = (e.idx == i) ? e.resp : '0;
          vectors++;
          if (ares[i] !== want) begin
            miscompares++;
            $display("FAIL oresps%0d cyc=%0d got=%h required=%h", i, cyc, ares[i], want);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cbus_req_t mkreq(input logic wr, input logic [31:0] addr,
                                      input logic [3:0] strobe, input logic [31:0] data,
                                      input cbus_len_t len);
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = MSIZE4;
    r.addr     = addr;
    r.strobe   = strobe;
    r.data     = data;
    r.len      = len;
    return r;
  endfunction

  function automatic cbus_resp_t mkresp(input logic last, input logic [31:0] data);
    cbus_resp_t s;
    s.ready = 1'b1;
    s.last  = last;
    s.data  = data;
    return s;
  endfunction

  task automatic push(input cbus_req_t r, input int unsigned g, input cbus_resp_t s);
    exp_t e;
    e.cyc  = cyc;
    e.req  = r;
    e.idx  = g;
    e.resp = s;
    q.push_back(e);
  endtask

  task automatic check_quiet(input string name);
    cbus_req_t  areq;
    cbus_resp_t ares;
    @(negedge clk);
    areq = sel ? bus_fp.oreq : bus_rr.oreq;
    vectors++;
    if (areq.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s oreq.valid=%b required=0", name, areq.valid);
    end
    for (int i = 0; i < NI; i++) begin
      ares = sel ? bus_fp.oresps[i] : bus_rr.oresps[i];
      vectors++;
      if (ares !== '0) begin
        miscompares++;
        $display("FAIL %s oresps%0d=%h required=0", name, i, ares);
      end
    end
  endtask

  // Called in an IDLE cycle where the arbiter should grant g at the next edge;
  // returns in the IDLE cycle after completion.
  task automatic serve(input int unsigned g, input int nbeats, input logic [31:0] dbase,
                       input logic keep, input int late_beat, input int unsigned late_idx,
                       input cbus_req_t late_rq);
    tick();
    for (int k = 0; k < nbeats; k++) begin
      if (k == late_beat) rq[late_idx] = late_rq;
      bresp = mkresp(k == nbeats - 1, dbase + k);
      push(rq[g], g, bresp);
      tick();
    end
    bresp = '0;
    if (!keep) rq[g] = '0;
  endtask

  initial begin
    cbus_req_t ra, rb, none;
    none  = '0;
    sel   = 1'b0;
    rst_n = 1'b0;
    bresp = '0;
    for (int i = 0; i < NI; i++) rq[i] = '0;
    ra = mkreq(1'b0, 32'h0000_2000, 4'h0, 32'h0, MLEN2);
    rb = mkreq(1'b1, 32'h0000_3000, 4'hF, 32'hCAFE_0001, MLEN2);
    repeat (3) tick();

    // first cycle out of reset: request seen, outputs still idle
    rst_n = 1'b1;
    rq[1] = mkreq(1'b0, 32'h8000_0080, 4'h0, 32'h0, MLEN16);
    check_quiet("out_of_reset");
    serve(1, 16, 32'h1000_0000, 1'b0, -1, 0, none);

    // round-robin contention, both held valid: 0,1,0,1
    rq[0] = ra;
    rq[1] = rb;
    serve(0, 2, 32'h2000_0000, 1'b1, -1, 0, none);
    serve(1, 2, 32'h2100_0000, 1'b1, -1, 0, none);
    serve(0, 2, 32'h2200_0000, 1'b1, -1, 0, none);
    serve(1, 2, 32'h2300_0000, 1'b0, -1, 0, none);
    rq[0] = '0;

    // uncached single-beat write
    rq[0] = mkreq(1'b1, 32'h1FC0_0010, 4'hF, 32'hDEAD_BEEF, MLEN1);
    serve(0, 1, 32'h3000_0000, 1'b0, -1, 0, none);

    // lock: requester 1 arrives at beat 3 of a 16-beat write
    rq[0] = mkreq(1'b1, 32'h0000_4000, 4'hF, 32'h1234_5678, MLEN16);
    serve(0, 16, 32'h4000_0000, 1'b0, 3, 1, mkreq(1'b0, 32'h0000_5000, 4'h0, 32'h0, MLEN1));
    serve(1, 1, 32'h4100_0000, 1'b0, -1, 0, none);

    // leave prio pointing at 1, then reset in the middle of a burst from 1
    rq[0] = ra;
    serve(0, 1, 32'h5000_0000, 1'b0, -1, 0, none);
    rq[1] = mkreq(1'b0, 32'h0000_6000, 4'h0, 32'h0, MLEN16);
    tick();
    for (int k = 0; k <= 5; k++) begin
      bresp = mkresp(1'b0, 32'h6000_0000 + k);
      push(rq[1], 1, bresp);
      if (k == 5) rst_n = 1'b0;
      tick();
    end
    rst_n = 1'b1;
    rq[1] = '0;
    bresp = mkresp(1'b0, 32'h0000_5A5A);
    check_quiet("reset_abort");
    tick();
    bresp = '0;
    rq[0] = ra;
    rq[1] = rb;
    serve(0, 1, 32'h7000_0000, 1'b0, -1, 0, none);
    serve(1, 1, 32'h7100_0000, 1'b0, -1, 0, none);

    // fixed priority: requester 0 wins every time while both are valid
    sel   = 1'b1;
    rq[0] = ra;
    rq[1] = rb;
    serve(0, 2, 32'h8000_0000, 1'b1, -1, 0, none);
    serve(0, 2, 32'h8100_0000, 1'b1, -1, 0, none);
    serve(0, 2, 32'h8200_0000, 1'b0, -1, 0, none);
    serve(1, 1, 32'h8300_0000, 1'b0, -1, 0, none);

    repeat (3) tick();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover %0d expected beats never seen, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
